// File: rtl/pipeline_pkg.sv
// Types and constants shared between the fetch and decode stages:
// the IF/ID bundle and the canonical NOP encoding used for bubbles.
package pipeline_pkg;

  localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
  } ifid_t;

endpackage

// File: rtl/pc_reg.sv
// 32-bit register with a synchronous reset value and a load enable;
// used as the fetch program counter.
module pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (en) pc_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VAL;
    else       pc_q <= pc_d;
  end

  assign q = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage plus IF/ID pipeline register.
// Optional macro IF_MISALIGN_CHK_EN: word-align redirect targets and raise a sticky misalign flag.
import pipeline_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output ifid_t       outputs,
  output logic        fetch_misaligned
);

  logic [31:0] pc_plus4_f;
  logic [31:0] target_f;
  logic [31:0] pc_next_f;
  logic        pc_en;
  ifid_t       ifid_d;
  ifid_t       ifid_q;

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_d;
  logic misalign_q;

  assign target_f = {PCTargetE[31:2], 2'b00};

  always_comb begin
    misalign_d = misalign_q;
    if (PCSrcE && (PCTargetE[1:0] != 2'b00)) misalign_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign fetch_misaligned = misalign_q;
`else
  assign target_f         = PCTargetE;
  assign fetch_misaligned = 1'b0;
`endif

  // A redirect must never be dropped, so it forces the PC enable past StallF.
  assign pc_plus4_f = PCF + 32'd4;
  assign pc_next_f  = PCSrcE ? target_f : pc_plus4_f;
  assign pc_en      = PCSrcE | ~StallF;

  pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_next_f),
    .q     (PCF)
  );

  // The synchronous imem is addressed with the PC's next value so its data
  // lines up with PCF in the following cycle.
  always_comb begin
    imem_addr = PCF;
    if (reset)      imem_addr = RESET_PC;
    else if (pc_en) imem_addr = pc_next_f;
  end

  always_comb begin
    ifid_d = ifid_q;
    if (FlushD) begin
      ifid_d.instr   = NOP_INSTR;
      ifid_d.PC      = 32'd0;
      ifid_d.PCPlus4 = 32'd0;
    end else if (!StallD) begin
      ifid_d.instr   = imem_rdata;
      ifid_d.PC      = PCF;
      ifid_d.PCPlus4 = pc_plus4_f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q.instr   <= NOP_INSTR;
      ifid_q.PC      <= 32'd0;
      ifid_q.PCPlus4 <= 32'd0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign outputs = ifid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a synchronous imem model
// holding a recognisable word at every address.
import pipeline_pkg::*;

module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PCF;
  ifid_t       outputs;
  logic        fetch_misaligned;

  int compareCount;
  int mismatchCount;

`ifdef IF_MISALIGN_CHK_EN
  localparam logic [31:0] MISALIGN_PC   = 32'h0000_0044;
  localparam logic [31:0] MISALIGN_FLAG = 32'd1;
`else
  localparam logic [31:0] MISALIGN_PC   = 32'h0000_0046;
  localparam logic [31:0] MISALIGN_FLAG = 32'd0;
`endif

  if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .StallF           (StallF),
    .StallD           (StallD),
    .FlushD           (FlushD),
    .PCSrcE           (PCSrcE),
    .PCTargetE        (PCTargetE),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .PCF              (PCF),
    .outputs          (outputs),
    .fetch_misaligned (fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word stored at byte address a: tag in the top half, word index below.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {16'hC0DE, a[17:2]};
  endfunction

  always @(posedge clk) imem_rdata <= memWord(imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic sf, input logic sd, input logic fd,
                               input logic src, input logic [31:0] tgt);
    reset     = rst;
    StallF    = sf;
    StallD    = sd;
    FlushD    = fd;
    PCSrcE    = src;
    PCTargetE = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] ipc, input logic [31:0] ipc4);
    checkOutput({tag, ".PCF"},     PCF,             pc);
    checkOutput({tag, ".instr"},   outputs.instr,   instr);
    checkOutput({tag, ".PC"},      outputs.PC,      ipc);
    checkOutput({tag, ".PCPlus4"}, outputs.PCPlus4, ipc4);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    tick();
    tick();

    // Reset state
    checkState("reset", 32'h0, 32'h13, 32'h0, 32'h0);
    checkOutput("reset.misalign", {31'd0, fetch_misaligned}, 32'd0);
    checkOutput("reset.imem_addr", imem_addr, 32'h0);

    // Free run
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("run0.imem_rdata", imem_rdata, memWord(32'h0));
    checkOutput("run0.imem_addr", imem_addr, 32'h4);
    tick();
    checkState("run1", 32'h4, memWord(32'h0), 32'h0, 32'h4);
    tick();
    checkState("run2", 32'h8, memWord(32'h4), 32'h4, 32'h8);

    // Load-use stall at PCF = 8 for three cycles
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("stall.imem_addr0", imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkState("stall", 32'h8, memWord(32'h4), 32'h4, 32'h8);
      checkOutput("stall.imem_addr", imem_addr, 32'h8);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkState("resume1", 32'hC, memWord(32'h8), 32'h8, 32'hC);
    tick();
    checkState("resume2", 32'h10, memWord(32'hC), 32'hC, 32'h10);

    // Redirect with flush
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
    #1;
    checkOutput("redir.imem_addr", imem_addr, 32'h40);
    tick();
    checkState("redir1", 32'h40, 32'h13, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkState("redir2", 32'h44, memWord(32'h40), 32'h40, 32'h44);

    // Redirect overrides StallF
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80);
    tick();
    checkState("redirStall1", 32'h80, 32'h13, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkState("redirStall2", 32'h84, memWord(32'h80), 32'h80, 32'h84);

    // Flush beats StallD
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkState("flushStall1", 32'h84, 32'h13, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkState("flushStall2", 32'h88, memWord(32'h84), 32'h84, 32'h88);

    // PC wraps from the top of the address space
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    tick();
    checkState("wrap1", 32'hFFFF_FFFC, 32'h13, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("wrap.imem_addr", imem_addr, 32'h0);
    tick();
    checkState("wrap2", 32'h0, memWord(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0);

    // Misaligned redirect target
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h46);
    tick();
    checkOutput("misalign.PCF", PCF, MISALIGN_PC);
    checkOutput("misalign.flag1", {31'd0, fetch_misaligned}, MISALIGN_FLAG);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("misalign.flag2", {31'd0, fetch_misaligned}, MISALIGN_FLAG);

    // Reset dominates a concurrent redirect and stall
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
    #1;
    checkOutput("rstDom.imem_addr", imem_addr, 32'h0);
    tick();
    checkState("rstDom", 32'h0, 32'h13, 32'h0, 32'h0);
    checkOutput("rstDom.misalign", {31'd0, fetch_misaligned}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkState("postRst", 32'h4, memWord(32'h0), 32'h0, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register: the producer of the `ifid_t` bundle that the decode stage consumes. It owns the fetch program counter and drives a synchronous-read instruction memory. It applies hazard-unit stall/flush and execute-stage redirects, and registers `{instr, PC, PCPlus4}` into the IF/ID boundary each cycle.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): instruction injected on flush or reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `StallF`  in  1  hold PCF.
- `StallD`  in  1  hold the IF/ID register.
- `FlushD`  in  1  replace the IF/ID contents with a bubble.
- `PCSrcE`  in  1  taken branch or jump resolved in EX.
- `PCTargetE`  in  32  redirect target.
- `imem_addr`  out  32  byte address presented to the synchronous imem.
- `imem_rdata`  in  32  word returned one cycle after `imem_addr`.
- `PCF`  out  32  current fetch PC.
- `outputs`  out  `ifid_t`  fields `instr`, `PC`, `PCPlus4`.
- `fetch_misaligned`  out  1  sticky misaligned-redirect flag.

## Operation
- `PCNextF` is `PCTargetE` when `PCSrcE` is high, otherwise `PCF + 4`. Addition is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- PC register:
  - `reset` loads `RESET_PC`.
  - Otherwise, if `PCSrcE` is high, load `PCNextF`. The redirect overrides `StallF` so it is never lost.
  - Otherwise, if `StallF` is high, hold.
  - Otherwise, load `PCNextF`.
- `imem_addr` is combinational:
  - `RESET_PC` while `reset` is high.
  - Otherwise it equals the value PCF will take at the next edge: `PCNextF` when advancing or redirecting, `PCF` when stalled.
- Result: in every cycle `imem_rdata` is the word at the current `PCF`.
- IF/ID register priority:
  1. `reset` or `FlushD` loads `instr = NOP_INSTR`, `PC = 0`, `PCPlus4 = 0`. Flush beats stall.
  2. `StallD` holds all fields.
  3. Otherwise capture `instr = imem_rdata`, `PC = PCF`, `PCPlus4 = PCF + 4`.
- There is no internal FSM beyond the PC, the IF/ID register, and the misalign flag.

## Timing
- Reset values:
  - `PCF = RESET_PC`
  - `outputs.instr = NOP_INSTR`, `outputs.PC = 0`, `outputs.PCPlus4 = 0`
  - `fetch_misaligned = 0`
  - `imem_addr = RESET_PC` while `reset` is asserted.
- Fetch latency: the instruction at PCF appears on `outputs` one edge after PCF becomes current.
- The first cycle after reset deassertion shows `PCF = RESET_PC` with `imem_rdata = mem[RESET_PC]`. The next edge places that word in `outputs`.
- Redirect: the edge with `PCSrcE` high loads PCF with the target. The hazard unit asserts `FlushD` in the same cycle so the wrong-path word is discarded. The target instruction reaches `outputs` one edge later.
- `StallF` and `StallD` together (load-use): PCF, `imem_addr` and `outputs` are all unchanged. `imem` re-reads the same address, so the data stays consistent.
- Reset mid-stall or mid-redirect: reset dominates all other inputs.

## Configuration
- With `IF_MISALIGN_CHK_EN` defined:
  - A redirect with `PCTargetE[1:0] != 0` sets `fetch_misaligned`, which stays set until reset.
  - PCF loads `{PCTargetE[31:2], 2'b00}`.
- Without the macro:
  - The target is loaded verbatim.
  - `fetch_misaligned` is tied to 0.

## Structure
- `ifid_t` (`instr`, `PC`, `PCPlus4`) and the NOP encoding constant live in `pipeline_pkg`, shared with decode.
- `RESET_PC` stays a module parameter.
- One sub-module, `pc_reg`: a 32-bit register with synchronous reset value and enable, reused for PCF.
- The IF/ID register is inline.

## Test plan
- Reset then free run, imem holding word n at address 4n: `outputs.PC` steps 0, 4, 8 with matching `instr`, and `PCPlus4` equals `PC + 4`.
- `StallF` and `StallD` held for 3 cycles at PCF = 8: PCF, `imem_addr` and `outputs` are frozen. After release, fetch resumes at 8 with no skipped or duplicated PC.
- `PCSrcE = 1`, `PCTargetE = 32'h40`, `FlushD = 1`:
  - Next edge: PCF = 0x40 and `outputs.instr = 32'h13`.
  - Following edge: `outputs.PC = 0x40`.
- `PCSrcE` and `StallF` asserted in the same cycle: the redirect wins and PCF = target.
- `FlushD` and `StallD` asserted together: `outputs` becomes the bubble.
- `IF_MISALIGN_CHK_EN` defined, redirect to 32'h46: PCF = 0x44 and `fetch_misaligned = 1` until reset. Without the macro, PCF = 0x46 and the flag stays 0.
